// File: rtl/keypad_matrix_scanner.sv
// 4x3 matrix keypad scanner: row-at-a-time scan, full-frame debounce, multi-key rejection,
// level-held one-hot key outputs plus a one-cycle strobe with an encoded key code.
module keypad_matrix_scanner #(
    parameter int SCAN_DIV       = 2500,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       CLK,
    input  logic       RESETN,
    input  logic [2:0] KEY_COL,
    output logic [3:0] KEY_ROW,
    output logic [9:0] Keypad,
    output logic       KeypadHash,
    output logic       KeypadStar,
    output logic       KEY_VALID,
    output logic [3:0] KEY_CODE
);
    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int SW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [SW-1:0] STABLE_MAX = SW'(DEBOUNCE_SCANS);

    // Snapshot index 0..11 -> key code; packed low index first.
    localparam logic [47:0] CODE_LUT = {4'd11, 4'd0, 4'd10, 4'd9, 4'd8, 4'd7,
                                        4'd6,  4'd5, 4'd4,  4'd3, 4'd2, 4'd1};

    logic [DW-1:0] div_cnt;
    logic [1:0]    row_idx;
    logic [11:0]   raw;
    logic [11:0]   prev;
    logic [11:0]   new_frame;
    logic [SW-1:0] stable_cnt;
    logic [SW-1:0] stable_nxt;
    logic          row_done;
    logic          frame_done;
    logic          commit;
    logic          single_key;
    logic          commit_vld;
    logic [11:0]   commit_val;
    logic [11:0]   last_commit;
    logic [3:0]    key_enc;

    assign row_done   = (div_cnt == DW'(SCAN_DIV - 1));
    assign frame_done = row_done && (row_idx == 2'd3);
    assign KEY_ROW    = ~(4'b0001 << row_idx);

    always_comb begin
        new_frame = raw;
        new_frame[row_idx*3 +: 3] = ~KEY_COL;
    end

    always_comb begin
        if (new_frame != prev)
            stable_nxt = SW'(1);
        else if (stable_cnt == STABLE_MAX)
            stable_nxt = stable_cnt;
        else
            stable_nxt = stable_cnt + 1'b1;
    end

    // Commit only on the frame that first reaches the threshold, never while saturated.
    assign commit     = frame_done && (stable_nxt == STABLE_MAX) &&
                        !((new_frame == prev) && (stable_cnt == STABLE_MAX));
    assign single_key = ((new_frame & (new_frame - 12'd1)) == 12'd0);

    always_comb begin
        key_enc = 4'd0;
        for (int i = 0; i < 12; i++)
            if (commit_val[i]) key_enc = CODE_LUT[i*4 +: 4];
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            div_cnt     <= '0;
            row_idx     <= 2'd0;
            raw         <= 12'd0;
            prev        <= 12'd0;
            stable_cnt  <= '0;
            commit_vld  <= 1'b0;
            commit_val  <= 12'd0;
            last_commit <= 12'd0;
            Keypad      <= 10'd0;
            KeypadHash  <= 1'b0;
            KeypadStar  <= 1'b0;
            KEY_VALID   <= 1'b0;
            KEY_CODE    <= 4'd0;
        end else begin
            commit_vld <= 1'b0;
            KEY_VALID  <= 1'b0;

            if (row_done) begin
                div_cnt <= '0;
                row_idx <= row_idx + 2'd1;
                raw     <= new_frame;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end

            if (frame_done) begin
                prev       <= new_frame;
                stable_cnt <= stable_nxt;
                if (commit) begin
                    commit_vld <= 1'b1;
                    commit_val <= single_key ? new_frame : 12'd0;
                end
            end

            // Output stage: decode the committed snapshot one cycle after commit.
            if (commit_vld) begin
                Keypad      <= {commit_val[8:0], commit_val[10]};
                KeypadStar  <= commit_val[9];
                KeypadHash  <= commit_val[11];
                last_commit <= commit_val;
                if ((commit_val != 12'd0) && (commit_val != last_commit)) begin
                    KEY_VALID <= 1'b1;
                    KEY_CODE  <= key_enc;
                end
            end
        end
    end
endmodule
